// File: rtl/voter_seq.sv
// Clocked N-voter ballot collector: one vote per voter per session, bounded window, one-hot verdict on valid/ready.
// Optional build macro VOTER_SEQ_VETO_EN gives voter 0 a veto (a recorded "no" forces fail and closes the session).
module voter_seq #(
    parameter  int N_VOTERS = 4,
    parameter  int TIMEOUT  = 16,
    localparam int CW       = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2:0]          O,
    output logic [CW-1:0]       yes_cnt,
    output logic [CW-1:0]       no_cnt,
    output logic                timed_out
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [N_VOTERS-1:0] voted, voted_nxt;
    logic [TW-1:0]       timer, timer_nxt;
    logic [CW-1:0]       yes_nxt, no_nxt;
    logic [2:0]          o_nxt;
    logic                to_nxt;

    logic [N_VOTERS-1:0] new_votes;
    logic [N_VOTERS-1:0] cand_voted;
    logic [CW-1:0]       yes_add, no_add;
    logic [CW-1:0]       cand_yes, cand_no;
    logic                all_voted, timer_done, veto;

    // Verdict at CW+1 bits so 2*yes never wraps.
    function automatic logic [2:0] verdict(input logic [CW-1:0] yes);
        logic [CW:0] twice_yes;
        logic [CW:0] n_ext;
        twice_yes = {yes, 1'b0};
        n_ext     = (CW + 1)'(N_VOTERS);
        if (twice_yes > n_ext)
            verdict = 3'b100;
        else if (twice_yes == n_ext)
            verdict = 3'b010;
        else
            verdict = 3'b001;
    endfunction

    assign new_votes  = vote_valid & ~voted;
    assign cand_voted = voted | vote_valid;
    assign cand_yes   = yes_cnt + yes_add;
    assign cand_no    = no_cnt + no_add;
    assign all_voted  = &cand_voted;
    assign timer_done = (timer == TW'(TIMEOUT - 1));

`ifdef VOTER_SEQ_VETO_EN
    assign veto = new_votes[0] & ~vote_yes[0];
`else
    assign veto = 1'b0;
`endif

    always_comb begin
        yes_add = '0;
        no_add  = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            yes_add = yes_add + CW'(new_votes[i] & vote_yes[i]);
            no_add  = no_add + CW'(new_votes[i] & ~vote_yes[i]);
        end
    end

    always_comb begin
        state_nxt = state;
        voted_nxt = voted;
        timer_nxt = timer;
        yes_nxt   = yes_cnt;
        no_nxt    = no_cnt;
        o_nxt     = O;
        to_nxt    = timed_out;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COLLECT;
                    voted_nxt = '0;
                    timer_nxt = '0;
                    yes_nxt   = '0;
                    no_nxt    = '0;
                    to_nxt    = 1'b0;
                end
            end
            COLLECT: begin
                voted_nxt = cand_voted;
                yes_nxt   = cand_yes;
                no_nxt    = cand_no;
                timer_nxt = timer + TW'(1);
                // All-voted and veto closes take priority over the timeout flag.
                if (all_voted || timer_done || veto) begin
                    state_nxt = RESULT;
                    to_nxt    = ~all_voted & ~veto;
                    o_nxt     = veto ? 3'b001 : verdict(cand_yes);
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                    o_nxt     = 3'b000;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            voted     <= '0;
            timer     <= '0;
            yes_cnt   <= '0;
            no_cnt    <= '0;
            O         <= 3'b000;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            voted     <= voted_nxt;
            timer     <= timer_nxt;
            yes_cnt   <= yes_nxt;
            no_cnt    <= no_nxt;
            O         <= o_nxt;
            timed_out <= to_nxt;
        end
    end

    assign busy      = (state != IDLE);
    assign res_valid = (state == RESULT);

endmodule
